uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Shares the single UART transmitter (valid/data byte interface, 868 clk/bit at 100 MHz, 115200 baud) between two byte requesters.
- Round-robin grant; each accepted byte goes to the transmitter as a one-cycle dout_vld pulse with held dout_data.
- The transmitter has no busy/ready output, so this block enforces a fixed frame hold time before the next issue.
- Sits between application byte sources (e.g. echo path, status reporter) and the transmitter.

Parameters:
- FRAME_CYCLES, 8680, hold cycles after each issue pulse. Must be >= 10*868 so the transmitter finishes the stop bit and is back in its wait state. Test benches may override with a small value.
- CNT_W, 16, width of the per-port sent-byte counters.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-high
- req0_vld  input  1  port 0 has a byte
- req0_data  input  8  port 0 byte
- req0_rdy  output  1  port 0 byte accepted this cycle (handshake = vld & rdy)
- req1_vld  input  1  port 1 has a byte
- req1_data  input  8  port 1 byte
- req1_rdy  output  1  port 1 byte accepted this cycle
- dout_vld  output  1  one-cycle start pulse to the transmitter
- dout_data  output  8  byte to the transmitter; stable from the issue cycle until the next handshake
- busy  output  1  high in ISSUE and HOLD
- grant_id  output  1  port of the most recent handshake
- sent_cnt0  output  CNT_W  handshakes completed on port 0, wraps
- sent_cnt1  output  CNT_W  handshakes completed on port 1, wraps

Behaviour:
- Reset: state=IDLE, dout_vld=0, dout_data=0, busy=0, grant_id=0, last_grant=1 (port 0 wins the first contention), hold counter=0, sent_cnt0=sent_cnt1=0. Both rdy=0 while rst=1.
- FSM states: IDLE, ISSUE, HOLD.
- IDLE, port selection:
  - Only one port valid: select that port.
  - Both valid: select the port != last_grant.
  - Neither valid: stay in IDLE.
- IDLE, handshake: reqN_rdy=1 combinationally for the selected port only, 0 for the other. In the handshake cycle register:
  - dout_data <= reqN_data
  - grant_id <= N
  - last_grant <= N
  - sent_cntN += 1 (mod 2^CNT_W)
  - next state = ISSUE
- ISSUE: exactly one cycle. dout_vld=1 (Moore decode of state), load hold counter with FRAME_CYCLES-1, go to HOLD.
- HOLD: decrement the counter each cycle; at 0 go to IDLE. HOLD lasts exactly FRAME_CYCLES cycles.
- rdy is 0 outside IDLE, so no request is accepted in ISSUE or HOLD. Requesters keep vld high and data stable until rdy.
- Latency and throughput:
  - Handshake at cycle T gives dout_vld at T+1.
  - The earliest next handshake is T+2+FRAME_CYCLES, so back-to-back spacing is FRAME_CYCLES+2 cycles.
- dout_data is held after ISSUE. Requester data changes after the handshake have no effect.
- Requester dropping vld while waiting: allowed, no side effect (no byte is consumed).
- Reset mid-ISSUE/HOLD: abort immediately. Go to IDLE with the reset values above, counters cleared. The transmitter shares rst and also returns to idle.
- Simultaneous rst and vld: rst wins, no handshake, counters stay 0.
- busy = (state != IDLE).

Test Plan:
- Single request: req0_vld=1, data=0x55 at cycle T in IDLE -> req0_rdy=1 at T; dout_vld=1 only at T+1 with dout_data=0x55; busy=1 from T+1 to T+1+FRAME_CYCLES; sent_cnt0=1; req1_rdy never 1.
- Contention after reset: both vld, data0=0xA1, data1=0xB2 -> port 0 handshakes first (0xA1 issued, grant_id=0). Port 1 handshakes exactly FRAME_CYCLES+2 cycles later (0xB2, grant_id=1).
- Sustained contention over 6 frames: issued bytes alternate 0,1,0,1,0,1; sent_cnt0=sent_cnt1=3; spacing between dout_vld pulses always FRAME_CYCLES+2.
- Data hold: change req0_data from 0x3C to 0xFF one cycle after handshake -> dout_data stays 0x3C through HOLD.
- Reset mid-HOLD: assert rst for 1 cycle halfway through HOLD -> next cycle busy=0, counters=0, dout_vld=0. A pending req1 is accepted on the first IDLE cycle after rst deasserts.
- Wrap (FRAME_CYCLES=4, CNT_W=3): 9 port-0 bytes -> sent_cnt0 sequence 1..7,0,1; last wraps without glitch.

Source files
------------

// File: rtl/uart_tx_arbiter_if.sv
// Byte request, transmitter and status signals between the application
// requesters and the UART transmit arbiter.
interface uart_tx_arbiter_if #(
    parameter int CNT_W = 16
);
    logic             req0_vld;
    logic [7:0]       req0_data;
    logic             req0_rdy;
    logic             req1_vld;
    logic [7:0]       req1_data;
    logic             req1_rdy;
    logic             dout_vld;
    logic [7:0]       dout_data;
    logic             busy;
    logic             grant_id;
    logic [CNT_W-1:0] sent_cnt0;
    logic [CNT_W-1:0] sent_cnt1;

    // Requester side: offers bytes and observes the transmitter/status outputs.
    modport master (
        output req0_vld, req0_data, req1_vld, req1_data,
        input  req0_rdy, req1_rdy, dout_vld, dout_data, busy, grant_id,
               sent_cnt0, sent_cnt1
    );

    // Arbiter side.
    modport slave (
        input  req0_vld, req0_data, req1_vld, req1_data,
        output req0_rdy, req1_rdy, dout_vld, dout_data, busy, grant_id,
               sent_cnt0, sent_cnt1
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART transmitter between two byte requesters,
// spacing issues by a fixed frame hold since the transmitter has no ready.
module uart_tx_arbiter #(
    parameter int FRAME_CYCLES = 8680,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    uart_tx_arbiter_if.slave bus
);
    localparam int HOLD_W = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(FRAME_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [7:0]        dout_data_q, dout_data_d;
    logic              grant_id_q, grant_id_d;
    logic              last_grant_q, last_grant_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [CNT_W-1:0]  sent_cnt0_q, sent_cnt0_d;
    logic [CNT_W-1:0]  sent_cnt1_q, sent_cnt1_d;

    logic sel1;
    logic hs0;
    logic hs1;

    // Port 1 wins when it is the only requester, or on contention when port 0 was served last.
    always_comb begin
        sel1 = bus.req1_vld & (~bus.req0_vld | ~last_grant_q);
        hs0  = (state_q == IDLE) & ~rst & bus.req0_vld & ~sel1;
        hs1  = (state_q == IDLE) & ~rst & sel1;
    end

    always_comb begin
        state_d      = state_q;
        dout_data_d  = dout_data_q;
        grant_id_d   = grant_id_q;
        last_grant_d = last_grant_q;
        hold_cnt_d   = hold_cnt_q;
        sent_cnt0_d  = sent_cnt0_q;
        sent_cnt1_d  = sent_cnt1_q;
        case (state_q)
            IDLE: begin
                if (hs0) begin
                    dout_data_d  = bus.req0_data;
                    grant_id_d   = 1'b0;
                    last_grant_d = 1'b0;
                    sent_cnt0_d  = sent_cnt0_q + CNT_ONE;
                    state_d      = ISSUE;
                end else if (hs1) begin
                    dout_data_d  = bus.req1_data;
                    grant_id_d   = 1'b1;
                    last_grant_d = 1'b1;
                    sent_cnt1_d  = sent_cnt1_q + CNT_ONE;
                    state_d      = ISSUE;
                end
            end
            ISSUE: begin
                hold_cnt_d = HOLD_LOAD;
                state_d    = HOLD;
            end
            HOLD: begin
                if (hold_cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    hold_cnt_d = hold_cnt_q - HOLD_ONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Reset also clears the issued byte so the transmitter input is known after an abort.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            dout_data_q  <= 8'h00;
            grant_id_q   <= 1'b0;
            last_grant_q <= 1'b1;
            hold_cnt_q   <= '0;
            sent_cnt0_q  <= '0;
            sent_cnt1_q  <= '0;
        end else begin
            state_q      <= state_d;
            dout_data_q  <= dout_data_d;
            grant_id_q   <= grant_id_d;
            last_grant_q <= last_grant_d;
            hold_cnt_q   <= hold_cnt_d;
            sent_cnt0_q  <= sent_cnt0_d;
            sent_cnt1_q  <= sent_cnt1_d;
        end
    end

    assign bus.req0_rdy  = hs0;
    assign bus.req1_rdy  = hs1;
    assign bus.dout_vld  = (state_q == ISSUE);
    assign bus.dout_data = dout_data_q;
    assign bus.busy      = (state_q != IDLE);
    assign bus.grant_id  = grant_id_q;
    assign bus.sent_cnt0 = sent_cnt0_q;
    assign bus.sent_cnt1 = sent_cnt1_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: a short-frame instance for arbitration,
// hold and reset behaviour, and a 3-bit counter instance for wrap-around.
module tb_uart_tx_arbiter;
    localparam int F  = 6;
    localparam int FB = 4;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_pass;
    int   cyc_n;
    int   last_issue;

    uart_tx_arbiter_if #(.CNT_W(16)) ifa ();
    uart_tx_arbiter_if #(.CNT_W(3))  ifb ();

    uart_tx_arbiter #(.FRAME_CYCLES(F), .CNT_W(16)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ifa.slave)
    );

    uart_tx_arbiter #(.FRAME_CYCLES(FB), .CNT_W(3)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ifb.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc_n = 0;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish (time %0t)", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Called in the IDLE cycle with the request already driven; returns in the ISSUE cycle.
    task automatic handshake(input logic port, input logic [7:0] data,
                             input logic [15:0] exp_cnt, input bit chk_spacing);
        #1;
        chk("rdy_selected", port ? ifa.req1_rdy : ifa.req0_rdy, 1);
        chk("rdy_other", port ? ifa.req0_rdy : ifa.req1_rdy, 0);
        tick();
        chk("issue_dout_vld", ifa.dout_vld, 1);
        chk("issue_dout_data", ifa.dout_data, data);
        chk("issue_grant_id", ifa.grant_id, port);
        chk("issue_busy", ifa.busy, 1);
        chk("issue_sent_cnt", port ? ifa.sent_cnt1 : ifa.sent_cnt0, exp_cnt);
        if (chk_spacing) chk("issue_spacing", cyc_n - last_issue, F + 2);
        last_issue = cyc_n;
    endtask

    // Walks the whole HOLD phase and lands on the following IDLE cycle.
    task automatic hold_frame(input logic [7:0] data);
        for (int i = 0; i < F; i++) begin
            tick();
            chk("hold_dout_vld", ifa.dout_vld, 0);
            chk("hold_busy", ifa.busy, 1);
            chk("hold_dout_data", ifa.dout_data, data);
            chk("hold_rdy", {ifa.req0_rdy, ifa.req1_rdy}, 0);
        end
        tick();
        chk("idle_busy", ifa.busy, 0);
        chk("idle_dout_vld", ifa.dout_vld, 0);
    endtask

    initial begin
        n_chk      = 0;
        n_pass     = 0;
        last_issue = 0;
        rst        = 1'b1;
        ifa.req0_vld  = 1'b0;
        ifa.req0_data = 8'h00;
        ifa.req1_vld  = 1'b0;
        ifa.req1_data = 8'h00;
        ifb.req0_vld  = 1'b0;
        ifb.req0_data = 8'h00;
        ifb.req1_vld  = 1'b0;
        ifb.req1_data = 8'h00;

        // Reset with a request pending: reset wins, nothing accepted
        tick();
        ifa.req0_vld  = 1'b1;
        ifa.req0_data = 8'h55;
        tick();
        chk("rst_rdy0", ifa.req0_rdy, 0);
        chk("rst_busy", ifa.busy, 0);
        chk("rst_dout_vld", ifa.dout_vld, 0);
        chk("rst_dout_data", ifa.dout_data, 8'h00);
        chk("rst_grant_id", ifa.grant_id, 0);
        chk("rst_sent_cnt0", ifa.sent_cnt0, 0);
        chk("rst_sent_cnt1", ifa.sent_cnt1, 0);

        // Single request on port 0
        rst = 1'b0;
        handshake(1'b0, 8'h55, 16'd1, 1'b0);
        ifa.req0_vld = 1'b0;
        hold_frame(8'h55);
        chk("single_sent_cnt1", ifa.sent_cnt1, 0);

        // Contention straight after reset: port 0 first, port 1 one frame later
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ifa.req0_vld  = 1'b1;
        ifa.req0_data = 8'hA1;
        ifa.req1_vld  = 1'b1;
        ifa.req1_data = 8'hB2;
        handshake(1'b0, 8'hA1, 16'd1, 1'b0);
        ifa.req0_vld = 1'b0;
        hold_frame(8'hA1);
        handshake(1'b1, 8'hB2, 16'd1, 1'b1);
        ifa.req1_vld = 1'b0;
        hold_frame(8'hB2);

        // Sustained contention over six frames
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ifa.req0_vld  = 1'b1;
        ifa.req0_data = 8'h10;
        ifa.req1_vld  = 1'b1;
        ifa.req1_data = 8'h20;
        for (int k = 0; k < 6; k++) begin
            handshake(k[0], k[0] ? 8'h20 : 8'h10, 16'(k / 2 + 1), k > 0);
            hold_frame(k[0] ? 8'h20 : 8'h10);
        end
        chk("sustain_sent_cnt0", ifa.sent_cnt0, 3);
        chk("sustain_sent_cnt1", ifa.sent_cnt1, 3);
        ifa.req0_vld = 1'b0;
        ifa.req1_vld = 1'b0;

        // Issued byte is held while the requester changes its data
        ifa.req0_vld  = 1'b1;
        ifa.req0_data = 8'h3C;
        handshake(1'b0, 8'h3C, 16'd4, 1'b0);
        ifa.req0_data = 8'hFF;
        ifa.req0_vld  = 1'b0;
        hold_frame(8'h3C);

        // Reset halfway through HOLD with port 1 pending
        ifa.req0_vld  = 1'b1;
        ifa.req0_data = 8'h77;
        handshake(1'b0, 8'h77, 16'd5, 1'b0);
        ifa.req0_vld  = 1'b0;
        ifa.req1_vld  = 1'b1;
        ifa.req1_data = 8'h99;
        repeat (F / 2) tick();
        rst = 1'b1;
        tick();
        chk("abort_busy", ifa.busy, 0);
        chk("abort_dout_vld", ifa.dout_vld, 0);
        chk("abort_dout_data", ifa.dout_data, 8'h00);
        chk("abort_sent_cnt0", ifa.sent_cnt0, 0);
        chk("abort_sent_cnt1", ifa.sent_cnt1, 0);
        chk("abort_rdy1_in_rst", ifa.req1_rdy, 0);
        rst = 1'b0;
        handshake(1'b1, 8'h99, 16'd1, 1'b0);
        chk("abort_after_sent_cnt0", ifa.sent_cnt0, 0);
        ifa.req1_vld = 1'b0;
        hold_frame(8'h99);

        // 3-bit counter wrap on the second instance
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ifb.req0_vld = 1'b1;
        for (int k = 0; k < 9; k++) begin
            ifb.req0_data = 8'(k + 8'h40);
            #1;
            chk("wrap_rdy0", ifb.req0_rdy, 1);
            tick();
            chk("wrap_dout_vld", ifb.dout_vld, 1);
            chk("wrap_dout_data", ifb.dout_data, 8'(k + 8'h40));
            chk("wrap_sent_cnt0", ifb.sent_cnt0, (k + 1) % 8);
            repeat (FB) tick();
            chk("wrap_hold_busy", ifb.busy, 1);
            chk("wrap_hold_cnt0", ifb.sent_cnt0, (k + 1) % 8);
            tick();
        end
        ifb.req0_vld = 1'b0;
        chk("wrap_sent_cnt1", ifb.sent_cnt1, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
